imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_byte_to_word.sv | 42 ++++
 rtl/imem_loader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    // Default instruction-memory capacity in 32-bit words.
    localparam int unsigned DEPTH_DEFAULT = 64;

    // Width of the big-endian word-count field at the head of a frame.
    localparam int unsigned LEN_W = 16;

    // Frame-parser states.
    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, re-arm pulse, imem write port and status bundle.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_data, start,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err
    );

    modport slave (
        input  in_valid, in_data, start,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err
    );
endinterface

// File: rtl/imem_loader_byte_to_word.sv
// Packs bytes MSB-first into 32-bit words; flags the 4th byte of each word.
module byte_to_word (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word_out
);
    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Shift in one byte per accepted transfer; clear drops any partial word.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[23:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // The word is complete on the transfer of its 4th byte; shift_d then holds it.
    assign word_done = byte_valid && (cnt_q == 2'd3);
    assign word_out  = shift_d;

    // Shift register and byte counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/data/checksum byte frame from the host,
// writes the words into instruction memory and releases the core when valid.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  len_n;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        ready;
    logic        xfer;
    logic        rearm;
    logic        word_done;
    logic [31:0] word;

    assign ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CSUM);
    assign xfer  = bus.in_valid && ready;

    byte_to_word u_b2w (
        .clk        (clk),
        .reset      (reset),
        .clear      (rearm),
        .byte_valid (xfer && (state_q == S_DATA)),
        .byte_in    (bus.in_data),
        .word_done  (word_done),
        .word_out   (word)
    );

    // Next-state, counters, checksum and the registered imem write port.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rearm   = 1'b0;
        len_n   = {len_q[LEN_W-1:8], bus.in_data};
        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    len_d   = {bus.in_data, 8'h00};
                    csum_d  = csum_q ^ bus.in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d  = len_n;
                    csum_d = csum_q ^ bus.in_data;
                    if ((len_n != '0) && (len_n <= LEN_W'(DEPTH))) state_d = S_DATA;
                    else                                           state_d = S_ERROR;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ bus.in_data;
                    if (word_done) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = word;
                        idx_d   = idx_q + LEN_W'(1);
                        if (idx_q == len_q - LEN_W'(1)) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (bus.in_data == csum_q) state_d = S_DONE;
                    else                       state_d = S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (bus.start) begin
                    rearm   = 1'b1;
                    state_d = S_LEN_HI;
                    len_d   = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            default: state_d = S_LEN_HI;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LEN_HI;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_reset  = (state_q != S_DONE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERROR);

endmodule
